mips32_data_mem_responder: RTL and testbench
============================================

// Module: mips32_data_mem_responder
// PURPOSE
//   Responder end of the pipeline's data-memory interface: serves single-word load/store
//   requests from the MIPS32 MEM stage over a valid/ready request channel and returns
//   results on a valid/ready response channel. Models a slow word-addressed data RAM with
//   programmable wait states. One outstanding request at a time; no request pipelining.
// PARAMETERS
//   DEPTH        1024  number of 32-bit words; legal word addresses are 0..DEPTH-1
//   WAIT_CYCLES  2     extra wait states per access, legal range 0..15
// PORTS
//   clk          in   1   single clock, all state updates on posedge
//   rst          in   1   asynchronous, active-high reset
//   req_valid    in   1   request present
//   req_ready    out  1   responder can accept a request
//   req_we       in   1   1 = store (SW), 0 = load (LW)
//   req_addr     in   32  word address, i.e. the effective address from the EX stage
//   req_wdata    in   32  store data, the B operand
//   rsp_valid    out  1   response present
//   rsp_ready    in   1   requester accepts the response
//   rsp_rdata    out  32  load data; 0 for stores and for errors
//   rsp_err      out  1   address was out of range (req_addr >= DEPTH)
//   busy         out  1   high in WAIT and RESP
// BEHAVIOUR
//   Reset (async, asserting immediately): state=IDLE, cnt=0, rsp_valid=0, rsp_rdata=0,
//     rsp_err=0, captured request registers=0. The memory array is NOT reset. The bench
//     preloads it hierarchically as mem[i].
//   FSM states and outputs:
//     IDLE: req_ready=1, busy=0.
//     WAIT: req_ready=0, busy=1.
//     RESP: req_ready=0, busy=1, rsp_valid=1.
//   IDLE -> WAIT on req_valid & req_ready (the accept edge). On this edge, capture
//     we/addr/wdata and load cnt <= WAIT_CYCLES.
//   WAIT, cnt != 0: cnt <= cnt-1, stay in WAIT.
//   WAIT, cnt == 0: perform the access on this edge, then go to RESP:
//     load in range:   rsp_rdata <= mem[addr], rsp_err <= 0
//     store in range:  mem[addr] <= wdata, rsp_rdata <= 0, rsp_err <= 0
//     out of range:    no array access, no write, rsp_rdata <= 0, rsp_err <= 1
//   RESP -> IDLE on rsp_ready. rsp_valid, rsp_rdata and rsp_err hold stable until
//     that handshake. rsp_valid drops on the handshake edge. rsp_rdata and rsp_err
//     hold their values until the next access.
//   Latency: for an accept at edge N, the access occurs at edge N+1+WAIT_CYCLES and
//     rsp_valid is high from that edge. With WAIT_CYCLES=2, rsp_valid is high 3 edges
//     after accept.
//   Range check uses the full 32-bit req_addr, so upper address bits are never ignored.
//     The array is indexed with the low clog2(DEPTH) bits only after the check passes.
//   req_valid asserted while not IDLE is ignored and not queued. The requester holds it.
//   The earliest next accept is the edge after the RESP->IDLE transition. A combinational
//     RESP-to-accept bypass is not permitted.
//   Reset asserted in WAIT: the pending access is abandoned and a pending store never
//     writes. Reset asserted in RESP: the response is dropped.
//   Changes on req_* inputs after the accept edge have no effect on the captured access.
// TESTING
//   1 Reset: assert rst mid-cycle -> req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0
//     immediately, without a clock edge.
//   2 Store then load, WAIT_CYCLES=2: SW addr 198 data 5040 -> rsp_valid 3 edges after
//     accept, err=0, mem[198]=5040. LW addr 198 -> rdata=5040.
//   3 Preloaded mem[200]=7, LW addr 200 -> rdata=7, err=0. LW addr 1024 -> err=1,
//     rdata=0. SW addr 32'h0000_0400+5 -> err=1 and mem[5] unchanged (no aliasing).
//   4 Back-pressure: hold rsp_ready=0 for 5 cycles -> rsp_valid, rdata and err stable,
//     req_ready=0, and a second req_valid is not accepted.
//   5 Reset during WAIT of SW addr 10 data 99, with mem[10]=1 -> mem[10] stays 1 and all
//     outputs return to reset values.
//   6 Streaming: req_valid and rsp_ready held high with WAIT_CYCLES=0, 4 alternating SW/LW
//     -> one accept every 3 edges and all data correct. Repeat with WAIT_CYCLES=15.

Source files
------------

// File: rtl/mips32_data_mem_responder.sv
// Data-memory responder for the MIPS32 MEM stage: word-addressed RAM behind a
// valid/ready request channel and a valid/ready response channel. Each access
// takes WAIT_CYCLES wait states, and only one access is in flight at a time.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   S_IDLE | ready for a request; req_ready=1
//   S_WAIT | request captured; the wait-state counter runs down to zero
//   S_RESP | access done; response held until rsp_ready
module mips32_data_mem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    logic [31:0] mem [DEPTH];

    state_t      state_q,     state_d;
    logic [3:0]  cnt_q,       cnt_d;
    logic        we_q,        we_d;
    logic [31:0] addr_q,      addr_d;
    logic [31:0] wdata_q,     wdata_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q,   rsp_err_d;
    logic        req_ready_q, req_ready_d;
    logic        busy_q,      busy_d;
    logic        rsp_valid_q, rsp_valid_d;

    logic          in_range;
    logic          mem_wr;
    logic [AW-1:0] idx;

    // Next-state, capture, wait-state countdown and access decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_wr      = 1'b0;
        // Compare the full 32-bit address so upper bits can never alias into the array.
        in_range    = (addr_q < 32'(DEPTH));
        idx         = addr_q[AW-1:0];

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = S_WAIT;
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = 4'(WAIT_CYCLES);
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_RESP;
                    if (!in_range) begin
                        rsp_rdata_d = 32'd0;
                        rsp_err_d   = 1'b1;
                    end else if (we_q) begin
                        mem_wr      = 1'b1;
                        rsp_rdata_d = 32'd0;
                        rsp_err_d   = 1'b0;
                    end else begin
                        rsp_rdata_d = mem[idx];
                        rsp_err_d   = 1'b0;
                    end
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        req_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
    end

    // Control and response registers; reset clears them immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // RAM write port. The array is not reset. mem_wr decodes from state_q, which reset
    // forces to S_IDLE, so a store abandoned by reset can never write.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[idx] <= wdata_q;
        end
    end

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mips32_data_mem_responder.sv
// Directed bench for mips32_data_mem_responder. It uses three instances:
// d=0 has WAIT_CYCLES=2, d=1 has WAIT_CYCLES=0 and d=2 has WAIT_CYCLES=15.
module tb_mips32_data_mem_responder;

    localparam int WC [3] = '{2, 0, 15};

    logic            clk = 1'b0;
    logic [2:0]      rst;
    logic [2:0]      req_valid, req_ready, req_we;
    logic [2:0]      rsp_valid, rsp_ready, rsp_err, busy;
    logic [2:0][31:0] req_addr, req_wdata, rsp_rdata;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    mips32_data_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) u_d0 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]), .busy(busy[0]));

    mips32_data_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) u_d1 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]), .busy(busy[1]));

    mips32_data_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(15)) u_d2 (
        .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]),
        .rsp_err(rsp_err[2]), .busy(busy[2]));

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] get_mem(input int d, input int a);
        case (d)
            0:       return u_d0.mem[a];
            1:       return u_d1.mem[a];
            default: return u_d2.mem[a];
        endcase
    endfunction

    task automatic set_mem(input int d, input int a, input logic [31:0] v);
        case (d)
            0:       u_d0.mem[a] = v;
            1:       u_d1.mem[a] = v;
            default: u_d2.mem[a] = v;
        endcase
    endtask

    // One complete transaction with rsp_ready held high: accept, wait for the
    // response, check latency and data, then complete the handshake. If hold is
    // set, req_valid stays high after the accept, which gives back-to-back streaming.
    task automatic xfer(input int d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd,
                        input logic exp_err, input string tag, input bit hold);
        int n;
        chk({tag, "_ready"}, 32'(req_ready[d]), 32'd1);
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_valid[d] = 1'b1;
        rsp_ready[d] = 1'b1;
        tick();
        if (!hold) req_valid[d] = 1'b0;
        req_we[d]    = ~we;
        req_addr[d]  = ~addr;
        req_wdata[d] = ~wdata;
        n = 0;
        while (!rsp_valid[d] && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(WC[d] + 1));
        chk({tag, "_rdata"}, rsp_rdata[d], exp_rd);
        chk({tag, "_err"}, 32'(rsp_err[d]), 32'(exp_err));
        tick();
        chk({tag, "_vdrop"}, 32'(rsp_valid[d]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cyc0;
        rst       = 3'b111;
        req_valid = '0;
        req_we    = '0;
        rsp_ready = '0;
        req_addr  = '0;
        req_wdata = '0;

        // Reset is applied before the first clock edge.
        #2;
        chk("rst0_ready", 32'(req_ready[0]), 32'd1);
        chk("rst0_valid", 32'(rsp_valid[0]), 32'd0);
        chk("rst0_err",   32'(rsp_err[0]),   32'd0);
        chk("rst0_rdata", rsp_rdata[0],      32'd0);
        chk("rst0_busy",  32'(busy[0]),      32'd0);
        tick();
        tick();
        rst = 3'b000;
        tick();

        set_mem(0, 200, 32'd7);
        set_mem(0, 5,   32'h0000_0055);
        set_mem(0, 10,  32'd1);

        // Store then load.
        xfer(0, 1'b1, 32'd198, 32'd5040, 32'd0, 1'b0, "sw198", 1'b0);
        chk("sw198_mem", get_mem(0, 198), 32'd5040);
        xfer(0, 1'b0, 32'd198, 32'd0, 32'd5040, 1'b0, "lw198", 1'b0);

        // Preloaded word, out-of-range loads, and a store that must not alias.
        xfer(0, 1'b0, 32'd200, 32'd0, 32'd7, 1'b0, "lw200", 1'b0);
        xfer(0, 1'b0, 32'd1024, 32'd0, 32'd0, 1'b1, "lw1024", 1'b0);
        xfer(0, 1'b0, 32'h8000_00C8, 32'd0, 32'd0, 1'b1, "lw_hi", 1'b0);
        xfer(0, 1'b1, 32'h0000_0405, 32'hDEAD_BEEF, 32'd0, 1'b1, "sw405", 1'b0);
        chk("sw405_mem5", get_mem(0, 5), 32'h0000_0055);

        // Back-pressure on the response channel.
        rsp_ready[0] = 1'b0;
        req_we[0]    = 1'b0;
        req_addr[0]  = 32'd200;
        req_valid[0] = 1'b1;
        tick();
        req_valid[0] = 1'b0;
        n = 0;
        while (!rsp_valid[0] && n < 40) begin
            tick();
            n++;
        end
        chk("bp_lat", 32'(n), 32'd3);
        req_addr[0]  = 32'd198;
        req_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 32'(rsp_valid[0]), 32'd1);
            chk("bp_rdata", rsp_rdata[0], 32'd7);
            chk("bp_err",   32'(rsp_err[0]), 32'd0);
            chk("bp_ready", 32'(req_ready[0]), 32'd0);
        end
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        tick();
        chk("bp_done_valid", 32'(rsp_valid[0]), 32'd0);
        chk("bp_done_ready", 32'(req_ready[0]), 32'd1);
        chk("bp_done_hold",  rsp_rdata[0], 32'd7);
        tick();
        chk("bp_not_queued", 32'(busy[0]), 32'd0);

        // Reset is asserted mid-cycle while a store sits in WAIT.
        req_we[0]    = 1'b1;
        req_addr[0]  = 32'd10;
        req_wdata[0] = 32'd99;
        req_valid[0] = 1'b1;
        tick();
        req_valid[0] = 1'b0;
        tick();
        chk("r5_busy_pre", 32'(busy[0]), 32'd1);
        #3;
        rst[0] = 1'b1;
        #1;
        chk("r5_ready", 32'(req_ready[0]), 32'd1);
        chk("r5_busy",  32'(busy[0]),      32'd0);
        chk("r5_valid", 32'(rsp_valid[0]), 32'd0);
        chk("r5_err",   32'(rsp_err[0]),   32'd0);
        chk("r5_rdata", rsp_rdata[0],      32'd0);
        tick();
        tick();
        rst[0] = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("r5_mem10", get_mem(0, 10), 32'd1);
        xfer(0, 1'b0, 32'd10, 32'd0, 32'd1, 1'b0, "r5_lw10", 1'b0);

        // Streaming with req_valid and rsp_ready held high, at both wait extremes.
        for (int d = 1; d < 3; d++) begin
            cyc0 = cyc;
            xfer(d, 1'b1, 32'd50, 32'hA5A5_0001, 32'd0, 1'b0, "st_sw50", 1'b1);
            xfer(d, 1'b0, 32'd50, 32'd0, 32'hA5A5_0001, 1'b0, "st_lw50", 1'b1);
            xfer(d, 1'b1, 32'd51, 32'h1234_5678, 32'd0, 1'b0, "st_sw51", 1'b1);
            xfer(d, 1'b0, 32'd51, 32'd0, 32'h1234_5678, 1'b0, "st_lw51", 1'b0);
            chk("st_cycles", 32'(cyc - cyc0), 32'(4 * (WC[d] + 3)));
            chk("st_mem51", get_mem(d, 51), 32'h1234_5678);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
